// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encoding, default
// reset vector and the opcode/funct values the class decoder keys on.
package mips_mc_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } mc_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  localparam logic [5:0] OpSpecial    = 6'h00;
  localparam logic [5:0] OpJ          = 6'h02;
  localparam logic [5:0] OpBeq        = 6'h04;
  localparam logic [5:0] OpLw         = 6'h23;
  localparam logic [5:0] OpSw         = 6'h2b;
  localparam logic [5:0] FunctJr      = 6'h08;
  localparam logic [5:0] FunctSyscall = 6'h0c;
  localparam logic [5:0] FunctAdd     = 6'h20;

endpackage

// File: rtl/mips_mc_pc.sv
// Program counter and pc+4 registers. pc+4 is captured at fetch; the PC itself only
// moves on retire, taking either the word-aligned redirect target or pc+4.
module mips_mc_pc #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_i,
  input  logic              retire_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_4_o
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ResetPc   = RESET_PC & AlignMask;

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] pc_plus_4_d, pc_plus_4_q;

  always_comb begin
    pc_d        = pc_q;
    pc_plus_4_d = pc_plus_4_q;
    if (fetch_i) begin
      pc_plus_4_d = pc_q + ADDR_W'(4);
    end
    if (retire_i) begin
      pc_d = redirect_i ? (redirect_pc_i & AlignMask) : pc_plus_4_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= ResetPc;
      pc_plus_4_q <= ResetPc + ADDR_W'(4);
    end else begin
      pc_q        <= pc_d;
      pc_plus_4_q <= pc_plus_4_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_plus_4_o = pc_plus_4_q;

endmodule

// File: rtl/mips_mc_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready memory handshakes,
// global run enable, halt-on-syscall and a wrapping retired-instruction counter.
module mips_mc_seq
  import mips_mc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_4,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              reg_write,
  input  logic              syscall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic              rf_we,
  output logic [2:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  mc_state_e        state_d, state_q;
  logic [31:0]      ir_d, ir_q;
  logic [CNT_W-1:0] retired_d, retired_q;
  logic             fetch_done;
  logic             retire;
  logic             run;

  // Strobes are suppressed while reset is held, even though the state already reads FETCH.
  assign run = en & ~rst;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    fetch_done = 1'b0;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    if (run) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_d       = imem_rdata;
            fetch_done = 1'b1;
            state_d    = StDecode;
          end
        end
        StDecode: begin
          state_d = syscall ? StHalt : StExec;
        end
        StExec: begin
          if (is_load || is_store) begin
            state_d = StMem;
          end else if (reg_write) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ready) begin
            if (is_load) begin
              state_d = StWb;
            end else begin
              retire  = 1'b1;
              state_d = StFetch;
            end
          end
        end
        StWb: begin
          rf_we   = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  mips_mc_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_i       (fetch_done),
    .retire_i      (retire),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .pc_plus_4_o   (pc_plus_4)
  );

  assign imem_addr = pc;
  assign ir        = ir_q;
  assign state     = state_q;
  assign halted    = (state_q == StHalt);
  assign retired   = retired_q;

endmodule

// File: tb/tb_mips_mc_seq.sv
// Randomized bench for mips_mc_seq: each instruction is expanded into its expected
// per-cycle phase list (from class, wait counts and stalls) and every cycle is checked.
module tb_mips_mc_seq;
  import mips_mc_pkg::*;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] RstPc    = 32'h0000_0100;

  localparam logic [2:0] PhF = 3'd0;
  localparam logic [2:0] PhD = 3'd1;
  localparam logic [2:0] PhE = 3'd2;
  localparam logic [2:0] PhM = 3'd3;
  localparam logic [2:0] PhW = 3'd4;
  localparam logic [2:0] PhH = 3'd5;

  typedef enum int {CAlu, CLoad, CStore, CBranch, CSys} cls_e;
  typedef struct {
    logic [2:0] ph;
    bit         en;
    bit         ir;
    bit         dr;
  } cyc_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus_4;
  logic              is_load, is_store, reg_write, syscall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dmem_req, dmem_we, dmem_ready, rf_we;
  logic [2:0]        state;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  mips_mc_seq #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RstPc),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4),
    .is_load     (is_load),
    .is_store    (is_store),
    .reg_write   (reg_write),
    .syscall     (syscall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .rf_we       (rf_we),
    .state       (state),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int unsigned       n_checks = 0;
  int unsigned       n_pass   = 0;
  logic [31:0]       pc_exp;
  logic [CNT_W-1:0]  ret_exp;
  cyc_t              seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Appends one phase lasting waits+1 cycles; the final cycle raises the matching ready.
  task automatic push_phase(input logic [2:0] ph, input int waits, input int stalls,
                            input bit rnd_stall);
    for (int i = 0; i <= waits; i++) begin
      bit last;
      if (i == 0) begin
        for (int s = 0; s < stalls; s++) seq.push_back('{ph, 1'b0, 1'b1, 1'b1});
      end
      if (rnd_stall && $urandom_range(0, 5) == 0) begin
        seq.push_back('{ph, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
      end
      last = (i == waits);
      seq.push_back('{ph, 1'b1,
                      (ph == PhF) ? last : 1'($urandom_range(0, 1)),
                      (ph == PhM) ? last : 1'($urandom_range(0, 1))});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state), 32'(PhF));
    check("rst_pc", pc, RstPc);
    check("rst_pc4", pc_plus_4, RstPc + 32'd4);
    check("rst_ir", ir, 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_strobes", {28'h0, imem_req, dmem_req, dmem_we, rf_we}, 32'h0);
    rst = 1'b0;
    #1;
    check("rel_imem_req", 32'(imem_req), 32'h1);
    @(posedge clk); #1;
    pc_exp  = RstPc;
    ret_exp = '0;
  endtask

  task automatic run_insn(input cls_e cls, input int iw, input int dw, input bit redir,
                          input logic [31:0] tgt, input int mem_stall, input bit rnd_stall,
                          input int abort_k);
    logic [31:0] word;
    bit          st;
    word = $urandom;
    unique case (cls)
      CAlu:    word = {OpSpecial, word[25:6], FunctAdd};
      CLoad:   word = {OpLw, word[25:0]};
      CStore:  word = {OpSw, word[25:0]};
      CBranch: word = {redir ? OpJ : OpBeq, word[25:0]};
      CSys:    word = {OpSpecial, word[25:6], FunctSyscall};
      default: word = '0;
    endcase
    st          = (cls == CStore);
    is_load     = (cls == CLoad);
    is_store    = st;
    reg_write   = (cls == CAlu) || (cls == CLoad);
    syscall     = (cls == CSys);
    redirect    = redir;
    redirect_pc = tgt;
    imem_rdata  = word;

    seq.delete();
    push_phase(PhF, iw, 0, rnd_stall);
    push_phase(PhD, 0, 0, rnd_stall);
    if (cls != CSys) begin
      push_phase(PhE, 0, 0, rnd_stall);
      if (cls == CLoad || cls == CStore) push_phase(PhM, dw, mem_stall, rnd_stall);
      if (cls == CLoad || cls == CAlu) push_phase(PhW, 0, 0, rnd_stall);
    end

    for (int k = 0; k < seq.size(); k++) begin
      cyc_t c;
      c = seq[k];
      if (k == abort_k) return;
      en = c.en; imem_ready = c.ir; dmem_ready = c.dr;
      @(negedge clk);
      check("state", 32'(state), 32'(c.ph));
      check("halted", 32'(halted), 32'h0);
      check("pc", pc, pc_exp);
      check("imem_addr", imem_addr, pc_exp);
      check("retired", 32'(retired), 32'(ret_exp));
      check("imem_req", 32'(imem_req), 32'(c.en && c.ph == PhF));
      check("dmem_req", 32'(dmem_req), 32'(c.en && c.ph == PhM));
      check("dmem_we", 32'(dmem_we), 32'(c.en && c.ph == PhM && st));
      check("rf_we", 32'(rf_we), 32'(c.en && c.ph == PhW));
      if (c.ph != PhF) begin
        check("ir", ir, word);
        check("pc_plus_4", pc_plus_4, pc_exp + 32'd4);
      end
      @(posedge clk); #1;
    end
    if (cls != CSys) begin
      pc_exp  = redir ? (tgt & ~32'd3) : pc_exp + 32'd4;
      ret_exp = ret_exp + 1'b1;
    end
    check("pc_after", pc, pc_exp);
    check("retired_after", 32'(retired), 32'(ret_exp));
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      cls_e c;
      c = cls_e'($urandom_range(0, 3));
      run_insn(c, $urandom_range(0, 3), $urandom_range(0, 3),
               (c == CBranch) ? 1'($urandom_range(0, 1)) : 1'b0,
               $urandom, 0, 1'b1, -1);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
    is_load = 1'b0; is_store = 1'b0; reg_write = 1'b0; syscall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    do_reset();

    run_insn(CAlu, 0, 0, 1'b0, 32'h0, 0, 1'b0, -1);
    check("alu_pc", pc, 32'h104);
    check("alu_retired", 32'(retired), 32'h1);
    run_insn(CLoad, 2, 3, 1'b0, 32'h0, 0, 1'b0, -1);
    run_insn(CBranch, 0, 0, 1'b1, 32'h203, 0, 1'b0, -1);
    check("beq_pc", pc, 32'h200);
    run_insn(CStore, 0, 0, 1'b0, 32'h0, 5, 1'b0, -1);
    run_insn(CLoad, 1, 0, 1'b0, 32'h0, 5, 1'b0, -1);
    run_insn(CBranch, 1, 0, 1'b0, 32'hdead_beef, 0, 1'b0, -1);
    run_random(14);

    // Abort a store in its second MEM wait cycle.
    run_insn(CStore, 0, 3, 1'b0, 32'h0, 0, 1'b0, 4);
    do_reset();
    run_random(17);
    check("wrap_retired", 32'(retired), 32'h1);

    run_insn(CBranch, 0, 0, 1'b1, 32'h13, 0, 1'b0, -1);
    check("jmp_pc", pc, 32'h10);
    run_insn(CSys, 0, 0, 1'b0, 32'h0, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom_range(0, 1)); imem_ready = 1'b1; dmem_ready = 1'b1;
      @(negedge clk);
      check("halt_state", 32'(state), 32'(PhH));
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_pc", pc, 32'h10);
      check("halt_retired", 32'(retired), 32'(ret_exp));
      check("halt_strobes", {28'h0, imem_req, dmem_req, dmem_we, rf_we}, 32'h0);
      @(posedge clk); #1;
    end
    do_reset();
    run_random(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_seq.md
# mips_mc_seq

Multi-cycle instruction sequencer for the next-generation MIPS core: owns PC, instruction register and a FETCH/DECODE/EXEC/MEM/WB state machine, so instruction and data memories may take a variable number of cycles via req/ready handshakes. Sits between the existing ifetch/idecode/control/exe/dmem datapath blocks, replacing the single-cycle "everything in one clock" sequencing. Parametrised in address width, reset vector and retired-instruction counter width; adds stall, halt-on-syscall and retire counting.

## Interface
- ADDR_W, 32, PC and memory address width (≥ 3)
- RESET_PC, 0, PC value after reset (low 2 bits must be 0)
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global run enable; 0 freezes sequencer
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register
- pc  out  ADDR_W  current instruction address
- pc_plus_4  out  ADDR_W  pc + 4, registered at fetch
- is_load, is_store, reg_write, syscall  in  1 each  class flags from control decoder (valid from DECODE on)
- redirect  in  1  branch taken / jump / jr this instruction (sampled at retire)
- redirect_pc  in  ADDR_W  target when redirect=1
- dmem_req  out  1  data memory request
- dmem_we  out  1  write strobe, valid with dmem_req
- dmem_ready  in  1  data access complete
- rf_we  out  1  register-file write pulse
- state  out  3  current state encoding (debug)
- halted  out  1  syscall reached
- retired  out  CNT_W  instructions retired since reset

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1; on imem_ready: ir←imem_rdata, pc_plus_4←pc+4 → DECODE.
- DECODE: one cycle; syscall → HALT (PC unchanged, not retired); else → EXEC.
- EXEC: one cycle; is_load|is_store → MEM; else reg_write → WB; else retire → FETCH.
- MEM: dmem_req=1, dmem_we=is_store; on dmem_ready: load → WB, store → retire → FETCH.
- WB: rf_we=1 for exactly this cycle; retire → FETCH.
- Retire: pc ← redirect ? {redirect_pc[ADDR_W-1:2],2'b00} : pc_plus_4; retired ← retired+1 (wraps modulo 2^CNT_W).
- HALT: absorbing until rst; all request/strobe outputs 0; halted=1.
- pc arithmetic modulo 2^ADDR_W; pc[1:0] always 0.
- en=0: state, pc, ir, retired hold; imem_req, dmem_req, dmem_we, rf_we forced 0; ready inputs ignored; resumes in same state (request re-issued) when en=1.
- ready inputs ignored unless corresponding req is high.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, pc_plus_4=RESET_PC+4, ir=0, retired=0, halted=0, all req/we outputs 0 while rst high; imem_req=1 first cycle after rst release with en=1.
- Zero-wait memories: ALU op 4 cycles, load 5, store 4, branch/jump 3, syscall 2 to HALT.
- Each wait cycle (ready=0) adds one cycle; imem_addr, dmem_req, dmem_we stable while waiting.
- All outputs registered or decoded from registered state only; no combinational ready→req path.
- Retire edge: pc, retired update on same clock edge as leaving WB/EXEC/MEM.
- rst asserted mid-access: immediate abort, outstanding request dropped; memory must tolerate.

## Structure
- Shared package mips_mc_pkg: state enum (FETCH=0 … HALT=5), default RESET_PC, opcode/funct constants used by the class decoder.
- One sub-module: mips_mc_pc (PC + pc_plus_4 register with redirect mux and alignment), parameter ADDR_W, RESET_PC.

## Test plan
- Reset, RESET_PC=0x100, zero-wait add → imem_addr=0x100, rf_we pulse at cycle 4, pc=0x104, retired=1.
- lw with imem 2 wait cycles, dmem 3 wait cycles → retires in 4+2+3+1=10 cycles, rf_we one cycle after dmem_ready.
- beq taken, redirect_pc=0x203 → pc=0x200 after 3 cycles; rf_we, dmem_req never asserted.
- en dropped during MEM for 5 cycles with dmem_ready=1 → no req, ready ignored, access completes after en=1.
- syscall at 0x10 → HALT after 2 cycles, halted=1, pc=0x10, retired unchanged; only rst exits.
- rst pulsed mid-MEM of sw; CNT_W=4 with 17 retires → outputs at reset values; retired wraps to 1.
